// File: rtl/coo_aggregate_responder.sv
// coo_aggregate_responder: aggregates FM*WM rows over a COO edge list and serves result rows to argmax (clk, reset, start, coo_address/coo_in, fm_wm_row_addr/fm_wm_row_in, read_row/adj_fm_wm_row, done)
module coo_aggregate_responder #(
  parameter int NUM_OF_NODES    = 6,
  parameter int WEIGHT_COLS     = 3,
  parameter int DOT_PROD_WIDTH  = 16,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_NUM_OF_ROWS = 2,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [COO_BW-1:0]         coo_address,
  input  logic [COO_BW-1:0]         coo_in [0:COO_NUM_OF_ROWS-1],
  output logic [COO_BW-1:0]         fm_wm_row_addr,
  input  logic [DOT_PROD_WIDTH-1:0] fm_wm_row_in [0:WEIGHT_COLS-1],
  input  logic [COO_BW-1:0]         read_row,
  output logic [DOT_PROD_WIDTH-1:0] adj_fm_wm_row [0:WEIGHT_COLS-1],
  output logic                      done
);
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic [COO_BW-1:0] cnt;
  logic [DOT_PROD_WIDTH-1:0] acc [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic last, hit, rd_ok;
  assign last  = cnt == COO_BW'(COO_NUM_OF_COLS - 1);
  assign hit   = (32'(coo_in[0]) < NUM_OF_NODES) && (32'(coo_in[1]) < NUM_OF_NODES);
  assign rd_ok = 32'(read_row) < NUM_OF_NODES;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = (state == IDLE || state == DONE) ? (start ? CLEAR : state) :
                (state == CLEAR) ? ACCUM :
                (last ? DONE : ACCUM);
  end
  always_ff @(posedge clk) begin
    if (reset || state == CLEAR) begin
      cnt <= '0;
      for (int i = 0; i < NUM_OF_NODES; i++)
        for (int k = 0; k < WEIGHT_COLS; k++)
          acc[i][k] <= '0;
    end else if (state == ACCUM) begin
      if (!last) cnt <= cnt + 1'b1;
      if (hit)
        for (int k = 0; k < WEIGHT_COLS; k++)
          acc[coo_in[1]][k] <= acc[coo_in[1]][k] + fm_wm_row_in[k];
    end
  end
  always_comb begin
    done           = state == DONE;
    coo_address    = (state == ACCUM) ? cnt : '0;
    fm_wm_row_addr = (state == ACCUM) ? coo_in[0] : '0;
    for (int k = 0; k < WEIGHT_COLS; k++)
      adj_fm_wm_row[k] = (done && rd_ok) ? acc[read_row][k] : '0;
  end
endmodule

// File: tb/tb_coo_aggregate_responder.sv
// tb_coo_aggregate_responder: directed self-checking bench for coo_aggregate_responder
module tb_coo_aggregate_responder;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] coo_address, fm_wm_row_addr, read_row = '0;
  logic [2:0] coo_in [0:1];
  logic [15:0] fm_wm_row_in [0:2];
  logic [15:0] adj_fm_wm_row [0:2];
  logic done;
  logic [2:0] src [0:7];
  logic [2:0] dst [0:7];
  logic [15:0] fm [0:7][0:2];
  logic [15:0] exp_row [0:5][0:2];
  int vectors = 0, miscompares = 0;

  coo_aggregate_responder dut (
    .clk(clk), .reset(reset), .start(start),
    .coo_address(coo_address), .coo_in(coo_in),
    .fm_wm_row_addr(fm_wm_row_addr), .fm_wm_row_in(fm_wm_row_in),
    .read_row(read_row), .adj_fm_wm_row(adj_fm_wm_row), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    coo_in[0] = src[coo_address];
    coo_in[1] = dst[coo_address];
    for (int k = 0; k < 3; k++) fm_wm_row_in[k] = fm[fm_wm_row_addr][k];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 8; r++) begin
      read_row = 3'(r);
      #1;
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s_r%0d_%0d", tag, r, k), 32'(adj_fm_wm_row[k]), r < 6 ? 32'(exp_row[r][k]) : 32'd0);
    end
  endtask

  task automatic run(input bit pulse_mid);
    int lat;
    read_row = 3'd1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("done_drop", 32'(done), 0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 3) begin
        chk("coo_addr", 32'(coo_address), 2);
        chk("fm_addr", 32'(fm_wm_row_addr), 32'(src[2]));
        chk("busy_read", 32'(adj_fm_wm_row[0]), 0);
        if (pulse_mid) start = 1;
      end
      if (lat == 4) start = 0;
    end
    chk("latency", lat, 7);
  endtask

  task automatic set_exp_swap;
    exp_row = '{'{16'd2, 16'd20, 16'd200}, '{16'd1, 16'd10, 16'd100}, '{16'd4, 16'd40, 16'd400},
                '{16'd3, 16'd30, 16'd300}, '{16'd6, 16'd60, 16'd600}, '{16'd5, 16'd50, 16'd500}};
  endtask

  task automatic set_swap;
    for (int r = 0; r < 8; r++) begin
      fm[r][0] = 16'(r + 1);
      fm[r][1] = 16'(10 * (r + 1));
      fm[r][2] = 16'(100 * (r + 1));
      src[r] = 3'(r);
      dst[r] = 3'(r ^ 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    set_swap;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(coo_address), 0);
    chk("rst_read", 32'(adj_fm_wm_row[0]), 0);
    reset = 0;
    // swap pairs with an ignored start pulse mid-accumulation
    run(1);
    set_exp_swap;
    check_all("swap");
    // fan-in: every edge lands on node 2
    for (int r = 0; r < 6; r++) dst[r] = 3'd2;
    run(0);
    for (int r = 0; r < 6; r++) for (int k = 0; k < 3; k++) exp_row[r][k] = 16'd0;
    exp_row[2] = '{16'd21, 16'd210, 16'd2100};
    check_all("fanin");
    // wrap-around and out-of-range skips
    fm[0] = '{16'hFFFF, 16'h8000, 16'd1};
    src = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    dst = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run(0);
    for (int r = 0; r < 6; r++) for (int k = 0; k < 3; k++) exp_row[r][k] = 16'd0;
    exp_row[1] = '{16'hFFFE, 16'h0000, 16'd2};
    check_all("wrap");
    // reset in the third accumulate cycle
    set_swap;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_addr", 32'(coo_address), 0);
    reset = 0;
    for (int r = 0; r < 6; r++) for (int k = 0; k < 3; k++) exp_row[r][k] = 16'd0;
    check_all("mid_rst");
    run(0);
    set_exp_swap;
    check_all("post_rst");
    // restart from DONE with new products; old sums must not leak through
    for (int r = 0; r < 8; r++) fm[r] = '{16'(r), 16'd0, 16'd1};
    run(0);
    exp_row = '{'{16'd1, 16'd0, 16'd1}, '{16'd0, 16'd0, 16'd1}, '{16'd3, 16'd0, 16'd1},
                '{16'd2, 16'd0, 16'd1}, '{16'd5, 16'd0, 16'd1}, '{16'd4, 16'd0, 16'd1}};
    check_all("restart");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
